// File: rtl/can_rx_destuff.sv
// CAN receive destuffer: SOF detect, stuff-bit removal/flagging, stuff-error check, destuffed bit count.
// Optional CAN_RX_STUFF_ERR_CNT_EN adds a saturating 8-bit stuff-error counter output err_cnt.
module can_rx_destuff #(
  parameter int POST_BITS = 10,
  parameter int IDLE_BITS = 11
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sp,
  input  logic       rx_bit,
  output logic       data_bit,
  output logic       data_valid,
  output logic       is_stuff,
  output logic [9:0] bit_count,
  output logic       stuff_err,
  output logic       in_frame,
  output logic       ide,
  output logic       rtr,
  output logic [3:0] dlc
`ifdef CAN_RX_STUFF_ERR_CNT_EN
  ,
  output logic [7:0] err_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STUFFED,
    S_STUFF_TAIL,
    S_POST,
    S_ERROR
  } state_t;

  localparam logic [7:0] L_POST_BITS = 8'(POST_BITS);
  localparam logic [7:0] L_IDLE_BITS = 8'(IDLE_BITS);

  state_t     r_state;
  logic [2:0] r_run;
  logic       r_last;
  logic [9:0] r_cnt;
  logic       r_data_bit;
  logic       r_data_valid;
  logic       r_is_stuff;
  logic       r_stuff_err;
  logic       r_in_frame;
  logic       r_ide;
  logic       r_rtr;
  logic [3:0] r_dlc;
  logic [7:0] r_post_cnt;
  logic [7:0] r_idle_cnt;

  state_t     w_state_nxt;
  logic [2:0] w_run_nxt;
  logic       w_last_nxt;
  logic [9:0] w_cnt_nxt;
  logic       w_data_bit_nxt;
  logic       w_data_valid_nxt;
  logic       w_is_stuff_nxt;
  logic       w_stuff_err_nxt;
  logic       w_in_frame_nxt;
  logic       w_ide_nxt;
  logic       w_rtr_nxt;
  logic [3:0] w_dlc_nxt;
  logic [7:0] w_post_nxt;
  logic [7:0] w_idle_nxt;

  logic [9:0] w_cnt_inc;
  logic [2:0] w_run_upd;
  logic [3:0] w_n;
  logic [9:0] w_end;
  logic [7:0] w_post_inc;
  logic [7:0] w_idle_inc;

  assign w_cnt_inc  = r_cnt + 10'd1;
  assign w_run_upd  = (rx_bit == r_last) ? (r_run + 3'd1) : 3'd1;
  assign w_post_inc = r_post_cnt + 8'd1;
  assign w_idle_inc = r_idle_cnt + 8'd1;

  // Stuffing region ends on the last CRC bit; data length saturates at 8 bytes.
  assign w_n   = r_rtr ? 4'd0 : ((r_dlc > 4'd8) ? 4'd8 : r_dlc);
  assign w_end = (r_ide ? 10'd54 : 10'd34) + {3'b000, w_n, 3'b000};

  always_comb begin
    w_state_nxt      = r_state;
    w_run_nxt        = r_run;
    w_last_nxt       = r_last;
    w_cnt_nxt        = r_cnt;
    w_data_bit_nxt   = r_data_bit;
    w_data_valid_nxt = 1'b0;
    w_is_stuff_nxt   = 1'b0;
    w_stuff_err_nxt  = 1'b0;
    w_in_frame_nxt   = r_in_frame;
    w_ide_nxt        = r_ide;
    w_rtr_nxt        = r_rtr;
    w_dlc_nxt        = r_dlc;
    w_post_nxt       = r_post_cnt;
    w_idle_nxt       = r_idle_cnt;
    if (sp) begin
      case (r_state)
        S_IDLE: begin
          if (!rx_bit) begin
            w_data_valid_nxt = 1'b1;
            w_data_bit_nxt   = 1'b0;
            w_cnt_nxt        = 10'd1;
            w_run_nxt        = 3'd1;
            w_last_nxt       = 1'b0;
            w_ide_nxt        = 1'b0;
            w_rtr_nxt        = 1'b0;
            w_dlc_nxt        = 4'd0;
            w_post_nxt       = 8'd0;
            w_in_frame_nxt   = 1'b1;
            w_state_nxt      = S_STUFFED;
          end
        end
        S_STUFFED: begin
          if (r_run == 3'd5) begin
            if (rx_bit != r_last) begin
              w_is_stuff_nxt = 1'b1;
              w_run_nxt      = 3'd1;
              w_last_nxt     = rx_bit;
            end else begin
              w_stuff_err_nxt = 1'b1;
              w_idle_nxt      = 8'd0;
              w_state_nxt     = S_ERROR;
            end
          end else begin
            w_data_valid_nxt = 1'b1;
            w_data_bit_nxt   = rx_bit;
            w_cnt_nxt        = w_cnt_inc;
            w_run_nxt        = w_run_upd;
            w_last_nxt       = rx_bit;
            // r_cnt is the index of this destuffed bit; extended frames re-load rtr after the SRR.
            if (r_cnt == 10'd12) w_rtr_nxt = rx_bit;
            if (r_cnt == 10'd13) w_ide_nxt = rx_bit;
            if (!r_ide && r_cnt >= 10'd15 && r_cnt <= 10'd18) w_dlc_nxt = {r_dlc[2:0], rx_bit};
            if (r_ide && r_cnt == 10'd32) w_rtr_nxt = rx_bit;
            if (r_ide && r_cnt >= 10'd35 && r_cnt <= 10'd38) w_dlc_nxt = {r_dlc[2:0], rx_bit};
            if (w_cnt_inc == w_end) begin
              w_state_nxt = (w_run_upd == 3'd5) ? S_STUFF_TAIL : S_POST;
            end
          end
        end
        S_STUFF_TAIL: begin
          if (rx_bit != r_last) begin
            w_is_stuff_nxt = 1'b1;
            w_run_nxt      = 3'd1;
            w_last_nxt     = rx_bit;
            w_state_nxt    = S_POST;
          end else begin
            w_stuff_err_nxt = 1'b1;
            w_idle_nxt      = 8'd0;
            w_state_nxt     = S_ERROR;
          end
        end
        S_POST: begin
          w_data_valid_nxt = 1'b1;
          w_data_bit_nxt   = rx_bit;
          w_cnt_nxt        = w_cnt_inc;
          w_post_nxt       = w_post_inc;
          if (w_post_inc == L_POST_BITS) begin
            w_in_frame_nxt = 1'b0;
            w_state_nxt    = S_IDLE;
          end
        end
        S_ERROR: begin
          if (rx_bit) begin
            w_idle_nxt = w_idle_inc;
            if (w_idle_inc == L_IDLE_BITS) begin
              w_in_frame_nxt = 1'b0;
              w_state_nxt    = S_IDLE;
            end
          end else begin
            w_idle_nxt = 8'd0;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_run        <= 3'd0;
      r_last       <= 1'b1;
      r_cnt        <= 10'd0;
      r_data_bit   <= 1'b0;
      r_data_valid <= 1'b0;
      r_is_stuff   <= 1'b0;
      r_stuff_err  <= 1'b0;
      r_in_frame   <= 1'b0;
      r_ide        <= 1'b0;
      r_rtr        <= 1'b0;
      r_dlc        <= 4'd0;
      r_post_cnt   <= 8'd0;
      r_idle_cnt   <= 8'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_run        <= w_run_nxt;
      r_last       <= w_last_nxt;
      r_cnt        <= w_cnt_nxt;
      r_data_bit   <= w_data_bit_nxt;
      r_data_valid <= w_data_valid_nxt;
      r_is_stuff   <= w_is_stuff_nxt;
      r_stuff_err  <= w_stuff_err_nxt;
      r_in_frame   <= w_in_frame_nxt;
      r_ide        <= w_ide_nxt;
      r_rtr        <= w_rtr_nxt;
      r_dlc        <= w_dlc_nxt;
      r_post_cnt   <= w_post_nxt;
      r_idle_cnt   <= w_idle_nxt;
    end
  end

  assign data_bit   = r_data_bit;
  assign data_valid = r_data_valid;
  assign is_stuff   = r_is_stuff;
  assign bit_count  = r_cnt;
  assign stuff_err  = r_stuff_err;
  assign in_frame   = r_in_frame;
  assign ide        = r_ide;
  assign rtr        = r_rtr;
  assign dlc        = r_dlc;

`ifdef CAN_RX_STUFF_ERR_CNT_EN
  logic [7:0] r_err_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_cnt <= 8'd0;
    end else if (w_stuff_err_nxt && r_err_cnt != 8'hFF) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_can_rx_destuff.sv
// Directed bench for can_rx_destuff: frames are built unstuffed, stuffed by a transmit-side encoder,
// then driven bit by bit; totals are checked against hand-computed constants.
module tb_can_rx_destuff;

  logic       clk = 1'b0;
  logic       reset;
  logic       sp;
  logic       rx_bit;
  logic       data_bit;
  logic       data_valid;
  logic       is_stuff;
  logic [9:0] bit_count;
  logic       stuff_err;
  logic       in_frame;
  logic       ide;
  logic       rtr;
  logic [3:0] dlc;
`ifdef CAN_RX_STUFF_ERR_CNT_EN
  logic [7:0] err_cnt;
`endif

  int errors = 0;
  int checks = 0;
  int n_dv, n_st, n_se;

  logic src_q[$];
  logic bus_q[$];
  int   kind_q[$];  // 0 data bit, 1 stuff bit, 2 bit that must raise stuff_err

  always #5 clk = ~clk;

  can_rx_destuff dut (
    .clk        (clk),
    .reset      (reset),
    .sp         (sp),
    .rx_bit     (rx_bit),
    .data_bit   (data_bit),
    .data_valid (data_valid),
    .is_stuff   (is_stuff),
    .bit_count  (bit_count),
    .stuff_err  (stuff_err),
    .in_frame   (in_frame),
    .ide        (ide),
    .rtr        (rtr),
    .dlc        (dlc)
`ifdef CAN_RX_STUFF_ERR_CNT_EN
    ,
    .err_cnt    (err_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    rx_bit = b;
    sp     = 1'b1;
    @(posedge clk);
    #1;
    sp = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic add(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) src_q.push_back(v[i]);
  endtask

  task automatic build_std(input logic [10:0] id, input logic r, input logic [3:0] d,
                           input logic [15:0] data, input int nbits, input logic [14:0] crc);
    src_q.delete();
    add(32'd0, 1);
    add(32'(id), 11);
    add(32'(r), 1);
    add(32'd0, 2);
    add(32'(d), 4);
    add(32'(data), nbits);
    add(32'(crc), 15);
    add(32'h2FF, 10);
  endtask

  task automatic build_ext(input logic [10:0] base, input logic [17:0] ext, input logic r,
                           input logic [3:0] d, input logic [15:0] data, input int nbits,
                           input logic [14:0] crc);
    src_q.delete();
    add(32'd0, 1);
    add(32'(base), 11);
    add(32'd3, 2);
    add(32'(ext), 18);
    add(32'(r), 1);
    add(32'd0, 2);
    add(32'(d), 4);
    add(32'(data), nbits);
    add(32'(crc), 15);
    add(32'h2FF, 10);
  endtask

  // Transmit-side stuffing over the first end_len bits, including a stuff bit after the last one.
  task automatic make_bus(input int end_len, input bit break_tail);
    int   run;
    logic last;
    bus_q.delete();
    kind_q.delete();
    run  = 0;
    last = 1'b1;
    for (int i = 0; i < src_q.size(); i++) begin
      bus_q.push_back(src_q[i]);
      kind_q.push_back(0);
      if (i < end_len) begin
        run  = (i > 0 && src_q[i] == last) ? run + 1 : 1;
        last = src_q[i];
        if (run == 5) begin
          if (break_tail && i == end_len - 1) begin
            bus_q.push_back(last);
            kind_q.push_back(2);
            break;
          end
          bus_q.push_back(~last);
          kind_q.push_back(1);
          last = ~last;
          run  = 1;
        end
      end
    end
  endtask

  task automatic run_frame(input int limit);
    int k;
    k    = 0;
    n_dv = 0;
    n_st = 0;
    n_se = 0;
    for (int j = 0; j < bus_q.size() && j < limit; j++) begin
      send_bit(bus_q[j]);
      if (data_valid) n_dv++;
      if (is_stuff) n_st++;
      if (stuff_err) n_se++;
      chk("is_stuff", 32'(is_stuff), 32'(kind_q[j] == 1));
      chk("stuff_err", 32'(stuff_err), 32'(kind_q[j] == 2));
      chk("data_valid", 32'(data_valid), 32'(kind_q[j] == 0));
      if (kind_q[j] == 0 && data_valid) begin
        chk("data_bit", 32'(data_bit), 32'(src_q[k]));
        chk("bit_count_run", 32'(bit_count), 32'(k + 1));
      end
      if (kind_q[j] == 0) k++;
    end
  endtask

  initial begin
    reset  = 1'b1;
    sp     = 1'b0;
    rx_bit = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bit_count", 32'(bit_count), 32'd0);
    chk("rst_in_frame", 32'(in_frame), 32'd0);
    chk("rst_pulses", 32'({data_valid, is_stuff, stuff_err, data_bit}), 32'd0);
    chk("rst_fields", 32'({ide, rtr, dlc}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) send_bit(1'b1);
    chk("idle_recessive", 32'(in_frame), 32'd0);

    // Standard data frame, ID 0, DLC 1, data 0xAA.
    build_std(11'h000, 1'b0, 4'd1, 16'h00AA, 8, 15'h5555);
    make_bus(42, 1'b0);
    run_frame(1000);
    chk("A_stuff_cnt", 32'(n_st), 32'd3);
    chk("A_dv_cnt", 32'(n_dv), 32'd52);
    chk("A_err_cnt", 32'(n_se), 32'd0);
    chk("A_bit_count", 32'(bit_count), 32'd52);
    chk("A_in_frame", 32'(in_frame), 32'd0);
    chk("A_fields", 32'({ide, rtr, dlc}), 32'd1);
    @(posedge clk);
    #1;
    chk("A_dv_one_clk", 32'(data_valid), 32'd0);

    // Standard remote frame, DLC 8: region ends at 34.
    build_std(11'h555, 1'b1, 4'd8, 16'h0000, 0, 15'h4CCC);
    make_bus(34, 1'b0);
    run_frame(1000);
    chk("B_stuff_cnt", 32'(n_st), 32'd0);
    chk("B_dv_cnt", 32'(n_dv), 32'd44);
    chk("B_err_cnt", 32'(n_se), 32'd0);
    chk("B_bit_count", 32'(bit_count), 32'd44);
    chk("B_in_frame", 32'(in_frame), 32'd0);
    chk("B_fields", 32'({ide, rtr, dlc}), 32'h18);

    // Extended data frame, DLC 2: region ends at 70.
    build_ext(11'h2AA, 18'h00FC0, 1'b0, 4'd2, 16'hF00F, 16, 15'h5555);
    make_bus(70, 1'b0);
    run_frame(1000);
    chk("C_stuff_cnt", 32'(n_st), 32'd6);
    chk("C_dv_cnt", 32'(n_dv), 32'd80);
    chk("C_err_cnt", 32'(n_se), 32'd0);
    chk("C_bit_count", 32'(bit_count), 32'd80);
    chk("C_in_frame", 32'(in_frame), 32'd0);
    chk("C_fields", 32'({ide, rtr, dlc}), 32'h22);

    // CRC ends with five dominant bits: stuff bit after the region.
    build_std(11'h000, 1'b0, 4'd1, 16'h00AA, 8, 15'h5560);
    make_bus(42, 1'b0);
    run_frame(1000);
    chk("E_stuff_cnt", 32'(n_st), 32'd4);
    chk("E_dv_cnt", 32'(n_dv), 32'd52);
    chk("E_err_cnt", 32'(n_se), 32'd0);
    chk("E_bit_count", 32'(bit_count), 32'd52);
    chk("E_in_frame", 32'(in_frame), 32'd0);

    // Same frame with a non-toggling tail bit.
    make_bus(42, 1'b1);
    run_frame(1000);
    chk("Eb_stuff_cnt", 32'(n_st), 32'd3);
    chk("Eb_dv_cnt", 32'(n_dv), 32'd42);
    chk("Eb_err_cnt", 32'(n_se), 32'd1);
    chk("Eb_in_frame", 32'(in_frame), 32'd1);
    repeat (10) send_bit(1'b1);
    chk("Eb_err_hold", 32'(in_frame), 32'd1);
    send_bit(1'b1);
    chk("Eb_recover", 32'(in_frame), 32'd0);

    // Six dominant bits from SOF, then recovery with a restarted recessive count.
    for (int i = 0; i < 6; i++) begin
      send_bit(1'b0);
      chk("D_stuff_err", 32'(stuff_err), 32'(i == 5));
      chk("D_in_frame", 32'(in_frame), 32'd1);
    end
    chk("D_bit_count", 32'(bit_count), 32'd5);
    chk("D_no_dv", 32'(data_valid), 32'd0);
    repeat (5) send_bit(1'b1);
    send_bit(1'b0);
    chk("D_err_no_dv", 32'(data_valid | stuff_err), 32'd0);
    repeat (10) send_bit(1'b1);
    chk("D_count_restart", 32'(in_frame), 32'd1);
    send_bit(1'b1);
    chk("D_leave_error", 32'(in_frame), 32'd0);
    send_bit(1'b0);
    chk("D_sof_dv", 32'(data_valid), 32'd1);
    chk("D_sof_count", 32'(bit_count), 32'd1);
    chk("D_sof_in_frame", 32'(in_frame), 32'd1);
    do_reset();

    // Asynchronous reset in the data field, sp ignored while reset is high.
    build_std(11'h000, 1'b0, 4'd1, 16'h00AA, 8, 15'h5555);
    make_bus(42, 1'b0);
    run_frame(26);
    chk("F_mid_count", 32'(bit_count), 32'd23);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("F_async_count", 32'(bit_count), 32'd0);
    chk("F_async_in_frame", 32'(in_frame), 32'd0);
    chk("F_async_fields", 32'({ide, rtr, dlc, data_bit}), 32'd0);
    rx_bit = 1'b0;
    sp     = 1'b1;
    @(posedge clk);
    #1;
    sp = 1'b0;
    chk("F_sp_in_reset", 32'({in_frame, data_valid, bit_count}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    send_bit(1'b0);
    chk("F_sof_dv", 32'({data_valid, data_bit}), 32'h2);
    chk("F_sof_count", 32'(bit_count), 32'd1);
    chk("F_sof_in_frame", 32'(in_frame), 32'd1);
    do_reset();

`ifdef CAN_RX_STUFF_ERR_CNT_EN
    chk("G_err_cnt_rst", 32'(err_cnt), 32'd0);
    for (int e = 0; e < 300; e++) begin
      repeat (6) send_bit(1'b0);
      repeat (11) send_bit(1'b1);
      if (e == 0) chk("G_err_cnt_first", 32'(err_cnt), 32'd1);
    end
    chk("G_err_cnt_sat", 32'(err_cnt), 32'd255);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
